// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: operand/result bundle between the EX stage and the
// M-extension sequencer.
//   master (EX stage): drives start, funct3, operand_a, operand_b, flush;
//                      observes busy, stall_req, result_valid, result.
//   slave (sequencer): the reverse.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, operand_a, operand_b, flush,
    input  busy, stall_req, result_valid, result
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, flush,
    output busy, stall_req, result_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32IM M-extension unit (MUL/MULH/MULHSU/MULHU/
// DIV/DIVU/REM/REMU). Radix-2 shift-add multiplier and restoring divider on
// operand magnitudes, followed by a sign fix-up cycle. Divide-by-zero and
// signed overflow complete straight from IDLE.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - muldiv_sequencer_if.slave (start/funct3/operands/flush in,
//           busy/stall_req/result_valid/result out)
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies in a single
// cycle (IDLE -> DONE); divides are unchanged.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int unsigned     CntW   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mcand_q;  // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;    // {hi, lo}: product, or {remainder, dividend/quotient}
  logic              q_neg_q;  // product / quotient is negative
  logic              r_neg_q;  // remainder is negative
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   result_q;

  // Decode of the incoming operation, only meaningful in IDLE.
  logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, short_res;

  always_comb begin
    is_div    = bus.funct3[2];
    a_signed  = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_signed  = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    a_neg     = a_signed & bus.operand_a[XLEN-1];
    b_neg     = b_signed & bus.operand_b[XLEN-1];
    a_mag     = a_neg ? -bus.operand_a : bus.operand_a;
    b_mag     = b_neg ? -bus.operand_b : bus.operand_b;
    div_zero  = is_div & (bus.operand_b == '0);
    div_ovf   = is_div & ~bus.funct3[0] & (bus.operand_a == MinNeg) & (bus.operand_b == '1);
    // funct3[1] selects remainder over quotient
    if (div_zero) short_res = bus.funct3[1] ? bus.operand_a : '1;
    else          short_res = bus.funct3[1] ? '0 : bus.operand_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extend to 2*XLEN; the truncated product is exact for every signedness.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  always_comb begin
    fast_a    = {{XLEN{a_signed & bus.operand_a[XLEN-1]}}, bus.operand_a};
    fast_b    = {{XLEN{b_signed & bus.operand_b[XLEN-1]}}, bus.operand_b};
    fast_prod = fast_a * fast_b;
  end
`endif

  // One iteration of the shift-add multiplier or the restoring divider.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] step_d;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & mcand_q};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    if (op_q[2]) begin
      // Borrow out of the trial subtraction means the divisor did not fit.
      step_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = q_neg_q ? -acc_q : acc_q;
    quot_fix = q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q    <= bus.funct3;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            cnt_q   <= CntW'(XLEN);
            mcand_q <= is_div ? b_mag : a_mag;
            acc_q   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            if (div_zero || div_ovf) begin
              result_q <= short_res;
              state_q  <= StDone;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              result_q <= (bus.funct3 == 3'b000) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
              state_q  <= StDone;
            end
`endif
            else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= step_d;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StFix;
        end
        StFix: begin
          result_q <= fix_res;
          state_q  <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StDone);
  assign bus.result       = result_q;
  // Low in DONE so the stalled instruction advances and captures the result.
  assign bus.stall_req    = ~bus.flush & (((state_q == StIdle) & bus.start) |
                                          (state_q == StCalc) | (state_q == StFix));
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer. Expected results
// are queued when an operation is issued and popped by a monitor on each
// result_valid pulse; latency, stall_req and busy are checked per cycle.
module tb_muldiv_sequencer;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat = 34;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor: every result_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, {32'h0, bus.result}, {32'h0, e.val});
      end
    end
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (f[2] && b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
    case (f)
      3'b000:  p = sa * sb;
      3'b001:  p = (sa * sb) >> 32;
      3'b010:  p = (sa * ub) >> 32;
      3'b011:  p = (ua * ub) >> 32;
      3'b100:  p = sa / sb;
      3'b101:  p = ua / ub;
      3'b110:  p = sa % sb;
      default: p = ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MulLat;
    if (b == 32'h0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DivLat;
  endfunction

  // Start an operation without queueing a result (it will be aborted).
  task automatic start_raw(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f; bus.operand_a = a; bus.operand_b = b; bus.flush = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.operand_a = $urandom; bus.operand_b = $urandom;
  endtask

  // Issue one op; cycle 0 is the start cycle. result_valid is expected in cycle lat.
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    int   seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f; bus.operand_a = a; bus.operand_b = b; bus.flush = 1'b0;
    e.tag = tag;
    e.val = exp;
    exp_q.push_back(e);
    seen = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, "_busy_idle"}, {63'h0, bus.busy}, 64'd0);
      if (bus.result_valid) begin
        seen = i;
        check({tag, "_stall_done"}, {63'h0, bus.stall_req}, 64'd0);
        check({tag, "_busy_done"}, {63'h0, bus.busy}, 64'd1);
        break;
      end
      if (i < lat) check({tag, "_stall"}, {63'h0, bus.stall_req}, 64'd1);
      @(posedge clk); #1;
      if (i == 0) begin
        // Later operand/funct3 changes must be ignored.
        bus.start = 1'b0; bus.funct3 = 3'($urandom);
        bus.operand_a = $urandom; bus.operand_b = $urandom;
      end
    end
    check({tag, "_latency"}, 64'(seen), 64'(lat));
    if (seen < 0 && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.funct3 = 3'b0; bus.operand_a = '0; bus.operand_b = '0;
    bus.flush = 1'b0;
    #12;
    check("rst_busy", {63'h0, bus.busy}, 64'd0);
    check("rst_valid", {63'h0, bus.result_valid}, 64'd0);
    check("rst_stall", {63'h0, bus.stall_req}, 64'd0);
    check("rst_result", {32'h0, bus.result}, 64'd0);
    @(negedge clk); reset = 1'b0;

    issue("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
    issue("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
    issue("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MulLat);
    issue("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
    issue("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DivLat);
    issue("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DivLat);
    issue("divu_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, DivLat);
    issue("remu_7_big", 3'b111, 32'd7, 32'hFFFF_FFF9, 32'd7, DivLat);
    issue("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    issue("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    issue("remu_7_big2", 3'b111, 32'd7, 32'hFFFF_FFF9, 32'd7, DivLat);

    // Flush in cycle 10 of a DIVU: no result, stall drops, result held.
    start_raw(3'b101, 32'd100, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {63'h0, bus.stall_req}, 64'd0);
    check("flush_result_hold", {32'h0, bus.result}, 64'd7);
    issue("divu_after_flush", 3'b101, 32'd100, 32'd3, 32'd33, DivLat);

    // Asynchronous reset in cycle 5 of a divide.
    start_raw(3'b101, 32'h1234_5678, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("arst_busy", {63'h0, bus.busy}, 64'd0);
    check("arst_stall", {63'h0, bus.stall_req}, 64'd0);
    check("arst_valid", {63'h0, bus.result_valid}, 64'd0);
    check("arst_result", {32'h0, bus.result}, 64'd0);
    @(negedge clk); reset = 1'b0;
    issue("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, MulLat);

    for (int k = 0; k < 12; k++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (k % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (k == 5) b = 32'hFFFF_FFFF;
      issue($sformatf("rand%0d_f%0d", k, f), f, a, b, ref_model(f, a, b), ref_lat(f, a, b));
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
